// File: rtl/fan_speed_ctrl.sv
// -----------------------------------------------------------------------------
// fan_speed_ctrl
//
// Turns debounced speed-button presses into a soft-ramped PWM fan drive and
// forces a ramp-down to off when the fan timer reports expiry. Also drives a
// one-hot speed-level LED bus for the front panel.
//
// Ports
//   clk            system clock
//   reset_p        asynchronous reset, active-high
//   btn_speed      one-cycle pulse, debounced speed button
//   timer_start    timer armed (level)
//   timer_expired  timer timeout level; a rising edge means expiry
//   pwm_out        fan PWM drive (registered)
//   speed_level    0 = off, 1..3 = selected level
//   duty           current ramped duty
//   ramping        high while duty has not yet reached the level's target
//   led            one-hot level indicator {L3, L2, L1, OFF}
//
// State table
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE      | level 0 and duty 0; a press starts the fan at level 1
//   RUN       | level selected by presses; falls back to IDLE once level 0
//             | and duty has ramped to 0; armed expiry forces STOPPING
//   STOPPING  | expiry ramp-down; presses ignored; IDLE once duty reaches 0
// -----------------------------------------------------------------------------
module fan_speed_ctrl #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PWM_DIV  = 4,
  parameter int unsigned RAMP_DIV = 1000,
  parameter int unsigned DUTY_L1  = 64,
  parameter int unsigned DUTY_L2  = 128,
  parameter int unsigned DUTY_L3  = 255
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic                btn_speed,
  input  logic                timer_start,
  input  logic                timer_expired,
  output logic                pwm_out,
  output logic [1:0]          speed_level,
  output logic [PWM_BITS-1:0] duty,
  output logic                ramping,
  output logic [3:0]          led
);

  // Divider counters need at least one bit even when the divide ratio is 1.
  localparam int unsigned TICK_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(PWM_DIV - 1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;

  localparam logic [PWM_BITS-1:0] TGT_L1 = PWM_BITS'(DUTY_L1);
  localparam logic [PWM_BITS-1:0] TGT_L2 = PWM_BITS'(DUTY_L2);
  localparam logic [PWM_BITS-1:0] TGT_L3 = PWM_BITS'(DUTY_L3);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          speed_level_q, speed_level_d;
  logic [3:0]          led_q, led_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_lat_q, duty_lat_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic                pwm_out_q, pwm_out_d;
  logic                timer_expired_q, timer_expired_d;

  logic [PWM_BITS-1:0] target;
  logic                exp_edge;
  logic                expire;
  logic                ramp_wrap;
  logic                tick_wrap;

  // ---------------------------------------------------------------------------
  // Expiry edge detect; an edge only counts while the timer is armed.
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_expired_d = timer_expired;
    exp_edge        = timer_expired & ~timer_expired_q;
    expire          = exp_edge & timer_start;
  end

  // ---------------------------------------------------------------------------
  // Target duty follows the registered level, so a level change retargets the
  // ramp on the very next ramp step.
  // ---------------------------------------------------------------------------
  always_comb begin
    target = '0;
    case (speed_level_q)
      2'd1:    target = TGT_L1;
      2'd2:    target = TGT_L2;
      2'd3:    target = TGT_L3;
      default: target = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Level FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    speed_level_d = speed_level_q;

    case (state_q)
      ST_IDLE: begin
        if (btn_speed) begin
          speed_level_d = speed_level_q + 2'd1;
          state_d       = ST_RUN;
        end
      end

      ST_RUN: begin
        // Expiry takes priority; a press in the same cycle is dropped.
        if (expire) begin
          speed_level_d = 2'd0;
          state_d       = ST_STOPPING;
        end else if (btn_speed) begin
          speed_level_d = speed_level_q + 2'd1;
        end else if (speed_level_q == 2'd0 && duty_q == '0) begin
          state_d = ST_IDLE;
        end
      end

      ST_STOPPING: begin
        // Completes regardless of timer_start; presses are ignored.
        if (duty_q == '0) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        speed_level_d = 2'd0;
      end
    endcase

    led_d = 4'b0001 << speed_level_d;
  end

  // ---------------------------------------------------------------------------
  // Duty ramp: one step toward target per ramp-counter wrap. The ramp counter
  // free-runs and is never restarted by level changes.
  // ---------------------------------------------------------------------------
  always_comb begin
    ramp_wrap  = (ramp_cnt_q == RAMP_LAST);
    ramp_cnt_d = ramp_wrap ? '0 : ramp_cnt_q + 1'b1;
    duty_d     = duty_q;
    if (ramp_wrap) begin
      if (duty_q < target) begin
        duty_d = duty_q + 1'b1;
      end else if (duty_q > target) begin
        duty_d = duty_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PWM generator. The compare value is only reloaded as the period counter
  // wraps to 0, so a duty change never produces a runt pulse mid-period.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick_wrap  = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    pwm_cnt_d  = tick_wrap ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    duty_lat_d = duty_lat_q;
    if (tick_wrap && pwm_cnt_q == PWM_LAST) begin
      duty_lat_d = duty_q;
    end
    pwm_out_d = (pwm_cnt_q < duty_lat_q);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q         <= ST_IDLE;
      speed_level_q   <= 2'd0;
      led_q           <= 4'b0001;
      duty_q          <= '0;
      duty_lat_q      <= '0;
      pwm_cnt_q       <= '0;
      tick_cnt_q      <= '0;
      ramp_cnt_q      <= '0;
      pwm_out_q       <= 1'b0;
      timer_expired_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      speed_level_q   <= speed_level_d;
      led_q           <= led_d;
      duty_q          <= duty_d;
      duty_lat_q      <= duty_lat_d;
      pwm_cnt_q       <= pwm_cnt_d;
      tick_cnt_q      <= tick_cnt_d;
      ramp_cnt_q      <= ramp_cnt_d;
      pwm_out_q       <= pwm_out_d;
      timer_expired_q <= timer_expired_d;
    end
  end

  assign pwm_out     = pwm_out_q;
  assign speed_level = speed_level_q;
  assign duty        = duty_q;
  assign led         = led_q;
  assign ramping     = (duty_q != target);

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fan_speed_ctrl
//
// Directed scenarios for fan_speed_ctrl with PWM_BITS=4, PWM_DIV=1,
// RAMP_DIV=2 and targets 4/8/15. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_fan_speed_ctrl;

  localparam int unsigned PB = 4;

  logic          clk = 1'b0;
  logic          reset_p = 1'b1;
  logic          btn_speed = 1'b0;
  logic          timer_start = 1'b0;
  logic          timer_expired = 1'b0;
  logic          pwm_out;
  logic [1:0]    speed_level;
  logic [PB-1:0] duty;
  logic          ramping;
  logic [3:0]    led;

  int n_cmp = 0;
  int n_bad = 0;

  fan_speed_ctrl #(
    .PWM_BITS(PB),
    .PWM_DIV (1),
    .RAMP_DIV(2),
    .DUTY_L1 (4),
    .DUTY_L2 (8),
    .DUTY_L3 (15)
  ) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .btn_speed    (btn_speed),
    .timer_start  (timer_start),
    .timer_expired(timer_expired),
    .pwm_out      (pwm_out),
    .speed_level  (speed_level),
    .duty         (duty),
    .ramping      (ramping),
    .led          (led)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- stimulus helpers (no checking inside) ----
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    btn_speed = 1'b1;
    step(1);
    btn_speed = 1'b0;
  endtask

  task automatic wait_duty(input logic [PB-1:0] want, input int budget, output int cyc);
    cyc = 0;
    while (duty !== want && cyc < budget) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic apply_reset();
    timer_expired = 1'b0;
    timer_start   = 1'b0;
    btn_speed     = 1'b0;
    @(negedge clk);
    reset_p = 1'b1;
    step(2);
    reset_p = 1'b0;
    step(1);
  endtask

  // ---- scenario 1: reset values, async reset mid-RUN ----
  task automatic test_reset();
    int c;
    step(1);
    n_cmp++; if (speed_level !== 2'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", speed_level); end
    n_cmp++; if (duty !== 4'd0) begin n_bad++; $display("FAIL rst_duty: got %0d want 0", duty); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (ramping !== 1'b0) begin n_bad++; $display("FAIL rst_ramping: got %b want 0", ramping); end
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL rst_led: got %b want 0001", led); end
    n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dut.state_q); end
    reset_p = 1'b0;
    step(1);
    press();
    press();
    wait_duty(4'd8, 40, c);
    n_cmp++; if (duty !== 4'd8) begin n_bad++; $display("FAIL midrun_duty: got %0d want 8", duty); end
    step(20);
    #2;
    reset_p = 1'b1;
    #1;
    n_cmp++; if (speed_level !== 2'd0) begin n_bad++; $display("FAIL async_level: got %0d want 0", speed_level); end
    n_cmp++; if (duty !== 4'd0) begin n_bad++; $display("FAIL async_duty: got %0d want 0", duty); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL async_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (ramping !== 1'b0) begin n_bad++; $display("FAIL async_ramping: got %b want 0", ramping); end
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL async_led: got %b want 0001", led); end
    step(1);
    reset_p = 1'b0;
    step(1);
    press();
    n_cmp++; if (speed_level !== 2'd1) begin n_bad++; $display("FAIL repress_level: got %0d want 1", speed_level); end
    n_cmp++; if (led !== 4'b0010) begin n_bad++; $display("FAIL repress_led: got %b want 0010", led); end
  endtask

  // ---- scenario 2: single press, ramp cadence, PWM duty cycle ----
  task automatic test_single_press();
    int cyc, last, bad_step, hi;
    logic [PB-1:0] prev;
    apply_reset();
    press();
    n_cmp++; if (speed_level !== 2'd1) begin n_bad++; $display("FAIL sp_level: got %0d want 1", speed_level); end
    n_cmp++; if (led !== 4'b0010) begin n_bad++; $display("FAIL sp_led: got %b want 0010", led); end
    n_cmp++; if (ramping !== 1'b1) begin n_bad++; $display("FAIL sp_ramping_on: got %b want 1", ramping); end
    cyc = 0; last = -1; bad_step = 0; prev = duty;
    while (duty !== 4'd4 && cyc < 30) begin
      step(1);
      cyc++;
      if (duty !== prev) begin
        if (duty !== prev + 4'd1) bad_step++;
        if (last >= 0 && cyc - last != 2) bad_step++;
        if (last < 0 && (cyc < 1 || cyc > 2)) bad_step++;
        last = cyc;
        prev = duty;
      end
    end
    n_cmp++; if (duty !== 4'd4) begin n_bad++; $display("FAIL sp_duty: got %0d want 4", duty); end
    n_cmp++; if (bad_step != 0) begin n_bad++; $display("FAIL sp_step_cadence: got %0d bad steps want 0", bad_step); end
    n_cmp++; if (cyc < 7 || cyc > 8) begin n_bad++; $display("FAIL sp_ramp_time: got %0d clks want 7..8", cyc); end
    n_cmp++; if (ramping !== 1'b0) begin n_bad++; $display("FAIL sp_ramping_off: got %b want 0", ramping); end
    step(40);
    hi = 0;
    repeat (16) begin
      if (pwm_out === 1'b1) hi++;
      step(1);
    end
    n_cmp++; if (hi != 4) begin n_bad++; $display("FAIL sp_pwm_high: got %0d of 16 want 4", hi); end
  endtask

  // ---- scenario 3: four presses cycle through all levels ----
  task automatic test_level_cycle();
    logic [1:0]    exp_lvl [4];
    logic [PB-1:0] exp_duty [4];
    logic [3:0]    exp_led [4];
    exp_lvl  = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_duty = '{4'd4, 4'd8, 4'd15, 4'd0};
    exp_led  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      press();
      n_cmp++; if (speed_level !== exp_lvl[i]) begin n_bad++; $display("FAIL lc_level[%0d]: got %0d want %0d", i, speed_level, exp_lvl[i]); end
      n_cmp++; if (led !== exp_led[i]) begin n_bad++; $display("FAIL lc_led[%0d]: got %b want %b", i, led, exp_led[i]); end
      step(39);
      n_cmp++; if (duty !== exp_duty[i]) begin n_bad++; $display("FAIL lc_duty[%0d]: got %0d want %0d", i, duty, exp_duty[i]); end
      n_cmp++; if (ramping !== 1'b0) begin n_bad++; $display("FAIL lc_ramping[%0d]: got %b want 0", i, ramping); end
    end
    n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL lc_state: got %0d want 0 (IDLE)", dut.state_q); end
  endtask

  // ---- scenario 4: armed expiry at level 3 ramps to off ----
  task automatic test_expiry_stop();
    int c, cyc, lvl_bad, hi;
    apply_reset();
    press();
    press();
    press();
    n_cmp++; if (speed_level !== 2'd3) begin n_bad++; $display("FAIL ex_level3: got %0d want 3", speed_level); end
    wait_duty(4'd15, 60, c);
    n_cmp++; if (duty !== 4'd15) begin n_bad++; $display("FAIL ex_duty15: got %0d want 15", duty); end
    step(20);
    timer_start   = 1'b1;
    timer_expired = 1'b1;
    step(1);
    n_cmp++; if (speed_level !== 2'd0) begin n_bad++; $display("FAIL ex_level0: got %0d want 0", speed_level); end
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL ex_led: got %b want 0001", led); end
    n_cmp++; if (dut.state_q !== 2'd2) begin n_bad++; $display("FAIL ex_state: got %0d want 2 (STOPPING)", dut.state_q); end
    cyc = 0; lvl_bad = 0;
    while (duty !== 4'd0 && cyc < 50) begin
      btn_speed = (cyc == 3 || cyc == 9);
      step(1);
      btn_speed = 1'b0;
      cyc++;
      if (speed_level !== 2'd0) lvl_bad++;
    end
    n_cmp++; if (duty !== 4'd0) begin n_bad++; $display("FAIL ex_duty0: got %0d want 0", duty); end
    n_cmp++; if (cyc < 29 || cyc > 30) begin n_bad++; $display("FAIL ex_ramp_time: got %0d clks want 29..30", cyc); end
    n_cmp++; if (lvl_bad != 0) begin n_bad++; $display("FAIL ex_btn_ignored: got %0d cycles with level!=0 want 0", lvl_bad); end
    step(1);
    n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL ex_idle: got %0d want 0 (IDLE)", dut.state_q); end
    step(20);
    hi = 0;
    repeat (32) begin
      if (pwm_out !== 1'b0) hi++;
      step(1);
    end
    n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL ex_pwm_off: got %0d high clks want 0", hi); end
    timer_expired = 1'b0;
    timer_start   = 1'b0;
  endtask

  // ---- scenario 5: press and expiry edge in the same cycle ----
  task automatic test_simultaneous();
    int c;
    apply_reset();
    timer_start = 1'b1;
    press();
    press();
    wait_duty(4'd8, 40, c);
    n_cmp++; if (duty !== 4'd8) begin n_bad++; $display("FAIL sim_duty8: got %0d want 8", duty); end
    btn_speed     = 1'b1;
    timer_expired = 1'b1;
    step(1);
    btn_speed = 1'b0;
    n_cmp++; if (speed_level !== 2'd0) begin n_bad++; $display("FAIL sim_level: got %0d want 0", speed_level); end
    n_cmp++; if (dut.state_q !== 2'd2) begin n_bad++; $display("FAIL sim_state: got %0d want 2 (STOPPING)", dut.state_q); end
    timer_start = 1'b0;
    step(30);
    n_cmp++; if (duty !== 4'd0) begin n_bad++; $display("FAIL sim_duty0: got %0d want 0", duty); end
    n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL sim_idle: got %0d want 0 (IDLE)", dut.state_q); end
    timer_expired = 1'b0;
  endtask

  // ---- scenario 6: expiry ignored when unarmed, and in IDLE ----
  task automatic test_expiry_ignored();
    int c;
    apply_reset();
    press();
    press();
    wait_duty(4'd8, 40, c);
    step(1);
    timer_start   = 1'b0;
    timer_expired = 1'b1;
    step(1);
    n_cmp++; if (speed_level !== 2'd2) begin n_bad++; $display("FAIL ig_level: got %0d want 2", speed_level); end
    n_cmp++; if (dut.state_q !== 2'd1) begin n_bad++; $display("FAIL ig_state: got %0d want 1 (RUN)", dut.state_q); end
    step(20);
    n_cmp++; if (duty !== 4'd8) begin n_bad++; $display("FAIL ig_duty: got %0d want 8", duty); end
    timer_expired = 1'b0;
    apply_reset();
    timer_start   = 1'b1;
    timer_expired = 1'b1;
    step(1);
    n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL ig_idle_state: got %0d want 0 (IDLE)", dut.state_q); end
    timer_expired = 1'b0;
    timer_start   = 1'b0;
    step(1);
    press();
    n_cmp++; if (speed_level !== 2'd1) begin n_bad++; $display("FAIL ig_idle_press: got %0d want 1", speed_level); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_level_cycle();
    test_expiry_stop();
    test_simultaneous();
    test_expiry_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
